// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready bitwise logic unit (8 ops) with a completed-beat counter.
// Define LOGIC_UNIT_POPCNT_EN to add a registered popcnt output alongside out_res.
module logic_unit_pipe #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_zero,
  output logic [CNT_W-1:0] txn_cnt
`ifdef LOGIC_UNIT_POPCNT_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0] popcnt
`endif
);

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NOR  = 3'b011,
    OP_NAND = 3'b100,
    OP_XNOR = 3'b101,
    OP_ANDN = 3'b110,
    OP_PASS = 3'b111
  } op_e;

  logic             s1_v_q, s1_v_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [2:0]       s1_op_q, s1_op_d;
  logic             s2_v_q, s2_v_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] op_res;
  logic             s1_rdy, s2_rdy;

  always_comb begin
    op_res = '0;
    case (op_e'(s1_op_q))
      OP_AND:  op_res = s1_a_q & s1_b_q;
      OP_OR:   op_res = s1_a_q | s1_b_q;
      OP_XOR:  op_res = s1_a_q ^ s1_b_q;
      OP_NOR:  op_res = ~(s1_a_q | s1_b_q);
      OP_NAND: op_res = ~(s1_a_q & s1_b_q);
      OP_XNOR: op_res = ~(s1_a_q ^ s1_b_q);
      OP_ANDN: op_res = s1_a_q & ~s1_b_q;
      OP_PASS: op_res = s1_a_q;
      default: op_res = '0;
    endcase
  end

  // Ready chain runs back from out_ready only; in_valid never feeds in_ready.
  assign s2_rdy   = !s2_v_q || out_ready;
  assign s1_rdy   = !s1_v_q || s2_rdy;
  assign in_ready = s1_rdy;

  always_comb begin
    s1_v_d  = s1_v_q;
    s1_a_d  = s1_a_q;
    s1_b_d  = s1_b_q;
    s1_op_d = s1_op_q;
    s2_v_d  = s2_v_q;
    res_d   = res_q;
    zero_d  = zero_q;
    cnt_d   = cnt_q;
    if (s1_rdy) begin
      s1_v_d = in_valid;
      if (in_valid) begin
        s1_a_d  = in_a;
        s1_b_d  = in_b;
        s1_op_d = in_op;
      end
    end
    // A bubble entering S2 only clears the valid; result data is left as-is.
    if (s2_rdy) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        res_d  = op_res;
        zero_d = (op_res == '0);
      end
    end
    if (s2_v_q && out_ready) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q  <= 1'b0;
      s1_a_q  <= '0;
      s1_b_q  <= '0;
      s1_op_q <= '0;
      s2_v_q  <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_v_q  <= s1_v_d;
      s1_a_q  <= s1_a_d;
      s1_b_q  <= s1_b_d;
      s1_op_q <= s1_op_d;
      s2_v_q  <= s2_v_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = s2_v_q;
  assign out_res   = res_q;
  assign out_zero  = zero_q;
  assign txn_cnt   = cnt_q;

`ifdef LOGIC_UNIT_POPCNT_EN
  localparam int PW = $clog2(WIDTH+1);

  logic [PW-1:0] pop_calc;
  logic [PW-1:0] pop_q, pop_d;

  always_comb begin
    pop_calc = '0;
    for (int i = 0; i < WIDTH; i++) pop_calc = pop_calc + PW'(op_res[i]);
  end

  always_comb begin
    pop_d = pop_q;
    if (s2_rdy && s1_v_q) pop_d = pop_calc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pop_q <= '0;
    else        pop_q <= pop_d;
  end

  assign popcnt = pop_q;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe (WIDTH=32, CNT_W=4); checks popcnt when
// LOGIC_UNIT_POPCNT_EN is defined.
module tb_logic_unit_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic [2:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic        out_zero;
  logic [3:0]  txn_cnt;
`ifdef LOGIC_UNIT_POPCNT_EN
  logic [5:0]  popcnt;
`endif

  logic_unit_pipe #(.WIDTH(32), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_zero  (out_zero),
`ifdef LOGIC_UNIT_POPCNT_EN
    .popcnt    (popcnt),
`endif
    .txn_cnt   (txn_cnt)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [3:0]  exp_cnt = 4'd0;
  logic [31:0] va [32];
  logic [31:0] vb [32];
  logic [2:0]  vop[32];
  logic [31:0] vexp[32];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic [31:0] e);
    va[i] = a; vb[i] = b; vop[i] = op; vexp[i] = e;
  endtask

  // Streams vectors 0..n-1; out_ready is held low for the first stall_len cycles.
  task automatic run_stream(input int n, input bit lat_chk, input int stall_len);
    int snd, rcv, cyc;
    int acc[32];
    bit fi, fo;
    snd = 0; rcv = 0; cyc = 0;
    while (rcv < n && cyc < 200) begin
      out_ready = (cyc >= stall_len);
      in_valid  = (snd < n);
      if (snd < n) begin
        in_a = va[snd]; in_b = vb[snd]; in_op = vop[snd];
      end
      #1;
      chk("txn_cnt", 64'(txn_cnt), 64'(exp_cnt));
      if (stall_len > 0 && cyc >= 2 && cyc < stall_len) begin
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_res", 64'(out_res), 64'(vexp[rcv]));
      end
      fi = in_valid && in_ready;
      fo = out_valid && out_ready;
      if (fo) begin
        chk("out_res", 64'(out_res), 64'(vexp[rcv]));
        chk("out_zero", 64'(out_zero), 64'(vexp[rcv] == 32'd0));
        if (lat_chk) chk("latency", 64'(cyc), 64'(acc[rcv] + 2));
`ifdef LOGIC_UNIT_POPCNT_EN
        chk("popcnt", 64'(popcnt), 64'($countones(vexp[rcv])));
`endif
        rcv++;
      end
      if (fi) begin
        acc[snd] = cyc;
        snd++;
      end
      step();
      if (fo) exp_cnt = exp_cnt + 4'd1;
      cyc++;
    end
    if (rcv < n) chk("stream_timeout", 64'(rcv), 64'(n));
    in_valid = 1'b0;
    #1;
    chk("drained_no_extra", 64'(out_valid), 64'd0);
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_res", 64'(out_res), 64'd0);
    chk("rst_out_zero", 64'(out_zero), 64'd0);
    chk("rst_txn_cnt", 64'(txn_cnt), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    #10 rst_n = 1'b1;
    step();

    // All eight ops, back to back
    set_vec(0, 32'hF0F0_00FF, 32'hFF00_0F0F, 3'b000, 32'hF000_000F);
    set_vec(1, 32'hF0F0_00FF, 32'hFF00_0F0F, 3'b001, 32'hFFF0_0FFF);
    set_vec(2, 32'hF0F0_00FF, 32'hFF00_0F0F, 3'b010, 32'h0FF0_0FF0);
    set_vec(3, 32'hF0F0_00FF, 32'hFF00_0F0F, 3'b011, 32'h000F_F000);
    set_vec(4, 32'hF0F0_00FF, 32'hFF00_0F0F, 3'b100, 32'h0FFF_FFF0);
    set_vec(5, 32'hF0F0_00FF, 32'hFF00_0F0F, 3'b101, 32'hF00F_F00F);
    set_vec(6, 32'hF0F0_00FF, 32'hFF00_0F0F, 3'b110, 32'h00F0_00F0);
    set_vec(7, 32'hF0F0_00FF, 32'hFF00_0F0F, 3'b111, 32'hF0F0_00FF);
    run_stream(8, 1'b1, 0);

    // Zero flag
    set_vec(0, 32'h1234_5678, 32'h1234_5678, 3'b010, 32'h0000_0000);
    run_stream(1, 1'b1, 0);

    // Back-pressure: out_ready low for 4 cycles while 5 beats stream in
    set_vec(0, 32'h0000_FFFF, 32'h00FF_00FF, 3'b000, 32'h0000_00FF);
    set_vec(1, 32'h1111_0000, 32'h0000_2222, 3'b001, 32'h1111_2222);
    set_vec(2, 32'hAAAA_AAAA, 32'hFFFF_0000, 3'b010, 32'h5555_AAAA);
    set_vec(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b100, 32'h0000_0000);
    set_vec(4, 32'h1234_5678, 32'h0000_FFFF, 3'b110, 32'h1234_0000);
    run_stream(5, 1'b0, 4);

    // Popcount extremes (out_res/out_zero checked in every build)
    set_vec(0, 32'hFFFF_FFFF, 32'h0000_0000, 3'b111, 32'hFFFF_FFFF);
    set_vec(1, 32'h0000_0000, 32'hFFFF_FFFF, 3'b111, 32'h0000_0000);
    run_stream(2, 1'b1, 0);

    // Reset with both stages full and the output stalled
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a = 32'hDEAD_BEEF; in_b = 32'h0; in_op = 3'b111;
    step();
    step();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_txn_cnt", 64'(txn_cnt), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_res", 64'(out_res), 64'd0);
    exp_cnt = 4'd0;
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("postrst_idle", 64'(out_valid), 64'd0);
    end

    // Throughput and counter wrap: 18 beats, one result per cycle
    for (int i = 0; i < 18; i++)
      set_vec(i, 32'(i + 1), 32'hFFFF_FFFF, 3'b111, 32'(i + 1));
    run_stream(18, 1'b1, 0);
    chk("txn_final", 64'(txn_cnt), 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
